// File: rtl/syn_vcortex_sram_dbg_cap.sv
//------------------------------------------------------------------------------
// syn_vcortex_sram_dbg_cap : SRAM bus snoop capture buffer, LB register readback.
// Optional address trigger: SYN_VCORTEX_SRAM_DBG_TRIG_EN.   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module syn_vcortex_sram_dbg_cap #(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic        clk_ir,
  input  logic        rst_ir,
  input  logic        sram_req,
  input  logic        sram_we,
  input  logic [17:0] sram_addr,
  input  logic [15:0] sram_wdata,
  input  logic        sram_rd_valid,
  input  logic [15:0] sram_rdata,
  input  logic        lb_rd_en,
  input  logic        lb_wr_en,
  input  logic [7:0]  lb_addr,
  input  logic [31:0] lb_wr_data,
  output logic        lb_wr_valid,
  output logic        lb_rd_valid,
  output logic [31:0] lb_rd_data
);
  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [C_CW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            cap_wr_en_q, cap_wr_en_d;
  logic            cap_rd_en_q, cap_rd_en_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [17:0]     rd_pipe_q [RD_LAT];
  logic [17:0]     rd_pipe_d [RD_LAT];
  logic            rd_pend_q, rd_pend_d;
  logic            rd_is_data_q, rd_is_data_d;
  logic [31:0]     rd_snap_q, rd_snap_d;
  logic            lb_wr_valid_q, lb_wr_valid_d;
  logic            lb_rd_valid_q, lb_rd_valid_d;
  logic [31:0]     lb_rd_data_q, lb_rd_data_d;
  logic [31:0]     ram_rdata_q;
  logic [31:0]     cap_mem_q [DEPTH];

  logic        wr_acc, rd_acc, arm, abort;
  logic        ev_rd, ev_wr, trig_hit, cap_do;
  logic [17:0] rd_addr_dly, ev_addr;
  logic [31:0] ev_entry, status_w, reg_rdata;
  logic        unused_ok;

  // A pending read blocks every new LB strobe until its data is returned.
  assign wr_acc = lb_wr_en && !rd_pend_q;
  assign rd_acc = lb_rd_en && !lb_wr_en && !rd_pend_q;
  assign arm    = wr_acc && (lb_addr == 8'h00) && lb_wr_data[0];
  assign abort  = wr_acc && (lb_addr == 8'h00) && lb_wr_data[1] && !lb_wr_data[0];

  assign rd_addr_dly = rd_pipe_q[RD_LAT-1];
  assign ev_rd       = sram_rd_valid && cap_rd_en_q;
  assign ev_wr       = sram_req && sram_we && cap_wr_en_q;
  assign ev_addr     = ev_rd ? rd_addr_dly : sram_addr;
  assign ev_entry    = ev_rd ? {1'b0, rd_addr_dly[14:0], sram_rdata}
                             : {1'b1, sram_addr[14:0], sram_wdata};

`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
  logic [17:0] trig_addr_q, trig_addr_d;
  logic [17:0] trig_mask_q, trig_mask_d;
  assign trig_hit = ((ev_addr ^ trig_addr_q) & trig_mask_q) == 18'd0;
`else
  assign trig_hit = 1'b1;
`endif

  assign cap_do = (ev_rd || ev_wr) && !arm && !abort &&
                  ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && trig_hit));

  assign unused_ok = ^{lb_wr_data, ev_addr};

  always_comb begin
    status_w                = '0;
    status_w[1:0]           = state_q;
    status_w[2]             = ovf_q;
    status_w[16 +: C_CW]    = count_q;
    reg_rdata = '0;
    case (lb_addr)
      8'h00: reg_rdata = {27'd0, cap_rd_en_q, cap_wr_en_q, 3'd0};
      8'h01: reg_rdata = status_w;
`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
      8'h02: reg_rdata = {14'd0, trig_addr_q};
      8'h03: reg_rdata = {14'd0, trig_mask_q};
`endif
      8'h04: reg_rdata[C_AW-1:0] = rd_ptr_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    cap_wr_en_d = cap_wr_en_q;
    cap_rd_en_d = cap_rd_en_q;
    rd_ptr_d    = rd_ptr_q;
`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
    trig_addr_d = trig_addr_q;
    trig_mask_d = trig_mask_q;
    if (wr_acc && lb_addr == 8'h02) trig_addr_d = lb_wr_data[17:0];
    if (wr_acc && lb_addr == 8'h03) trig_mask_d = lb_wr_data[17:0];
`endif
    if (wr_acc && lb_addr == 8'h00) begin
      cap_wr_en_d = lb_wr_data[3];
      cap_rd_en_d = lb_wr_data[4];
    end
    if (wr_acc && lb_addr == 8'h04) rd_ptr_d = lb_wr_data[C_AW-1:0];
    if (rd_acc && lb_addr == 8'h05) rd_ptr_d = rd_ptr_q + C_AW'(1);
    if (rd_acc && lb_addr == 8'h01) ovf_d = 1'b0;

    // Arm wins over a coincident capture; a collision set overrides a STATUS-read clear.
    if (arm) begin
`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
      state_d = ST_ARMED;
`else
      state_d = ST_CAPTURE;
`endif
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else if (cap_do) begin
      count_d = count_q + C_CW'(1);
      state_d = (count_d == C_CW'(DEPTH)) ? ST_DONE : ST_CAPTURE;
      if (ev_rd && ev_wr) ovf_d = 1'b1;
    end

    rd_pend_d    = rd_acc;
    rd_is_data_d = rd_is_data_q;
    rd_snap_d    = rd_snap_q;
    if (rd_acc) begin
      rd_is_data_d = (lb_addr == 8'h05);
      rd_snap_d    = reg_rdata;
    end
    lb_wr_valid_d = wr_acc;
    lb_rd_valid_d = rd_pend_q;
    lb_rd_data_d  = '0;
    if (rd_pend_q) lb_rd_data_d = rd_is_data_q ? ram_rdata_q : rd_snap_q;

    rd_pipe_d[0] = (sram_req && !sram_we) ? sram_addr : 18'd0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      cap_wr_en_q   <= 1'b1;
      cap_rd_en_q   <= 1'b1;
      rd_ptr_q      <= '0;
      rd_pend_q     <= 1'b0;
      rd_is_data_q  <= 1'b0;
      rd_snap_q     <= '0;
      lb_wr_valid_q <= 1'b0;
      lb_rd_valid_q <= 1'b0;
      lb_rd_data_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
      trig_addr_q   <= '0;
      trig_mask_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      cap_wr_en_q   <= cap_wr_en_d;
      cap_rd_en_q   <= cap_rd_en_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_pend_q     <= rd_pend_d;
      rd_is_data_q  <= rd_is_data_d;
      rd_snap_q     <= rd_snap_d;
      lb_wr_valid_q <= lb_wr_valid_d;
      lb_rd_valid_q <= lb_rd_valid_d;
      lb_rd_data_q  <= lb_rd_data_d;
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_d[i];
`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
      trig_addr_q   <= trig_addr_d;
      trig_mask_q   <= trig_mask_d;
`endif
    end
  end

  // Capture RAM has no reset; its registered output is the first DATA read stage.
  always_ff @(posedge clk_ir) begin
    if (cap_do) cap_mem_q[count_q[C_AW-1:0]] <= ev_entry;
    if (rd_acc && lb_addr == 8'h05) ram_rdata_q <= cap_mem_q[rd_ptr_q];
  end

  assign lb_wr_valid = lb_wr_valid_q;
  assign lb_rd_valid = lb_rd_valid_q;
  assign lb_rd_data  = lb_rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_syn_vcortex_sram_dbg_cap.sv
//------------------------------------------------------------------------------
// tb_syn_vcortex_sram_dbg_cap : randomized bench with a transaction-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_syn_vcortex_sram_dbg_cap;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic        clk_ir = 1'b0;
  logic        rst_ir;
  logic        sram_req, sram_we, sram_rd_valid;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        lb_rd_en, lb_wr_en;
  logic [7:0]  lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid, lb_rd_valid;
  logic [31:0] lb_rd_data;

  always #5 clk_ir = ~clk_ir;

  syn_vcortex_sram_dbg_cap #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_ir(clk_ir), .rst_ir(rst_ir),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rd_valid(sram_rd_valid), .sram_rdata(sram_rdata),
    .lb_rd_en(lb_rd_en), .lb_wr_en(lb_wr_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid),
    .lb_rd_data(lb_rd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: state 0..3, captured entries, and the memory's pending reads.
  int          m_state, m_count, m_rdptr, cyc;
  bit          m_ovf, m_capwr, m_caprd, m_block;
  logic [17:0] m_ta, m_tm;
  logic [31:0] m_mem [DEPTH];

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          due;
  } rd_t;
  rd_t pq[$];

  function automatic void m_capture(bit we, logic [17:0] a, logic [15:0] d, bit coll);
    bit take = 1'b0;
    if (m_state == 2) take = 1'b1;
    else if (m_state == 1 && ((a ^ m_ta) & m_tm) == 18'd0) take = 1'b1;
    if (!take) return;
    m_mem[m_count] = {we, a[14:0], d};
    m_count++;
    if (coll) m_ovf = 1'b1;
    m_state = (m_count == DEPTH) ? 3 : 2;
  endfunction

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    case (a)
      8'h00: return {27'd0, m_caprd, m_capwr, 3'd0};
      8'h01: return (32'(m_count) << 16) | (32'(m_ovf) << 2) | 32'(m_state);
      8'h02: return TRIG ? {14'd0, m_ta} : 32'd0;
      8'h03: return TRIG ? {14'd0, m_tm} : 32'd0;
      8'h04: return 32'(m_rdptr);
      8'h05: return m_mem[m_rdptr];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_lb_write(input logic [7:0] a, input logic [31:0] d);
    case (a)
      8'h00: begin
        m_capwr = d[3];
        m_caprd = d[4];
        if (d[0]) begin
          m_count = 0;
          m_ovf   = 1'b0;
          m_state = TRIG ? 1 : 2;
        end else if (d[1]) begin
          m_state = 0;
        end
      end
      8'h02: if (TRIG) m_ta = d[17:0];
      8'h03: if (TRIG) m_tm = d[17:0];
      8'h04: m_rdptr = int'(d & 32'(DEPTH - 1));
      default: ;
    endcase
  endfunction

  task automatic sram_step(input bit req, input bit we, input logic [17:0] a, input logic [15:0] d);
    bit  rv = 1'b0;
    rd_t r;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      r  = pq.pop_front();
      rv = 1'b1;
    end
    if (req && !we) pq.push_back('{a, d, cyc + RD_LAT});
    sram_req      = req;
    sram_we       = we;
    sram_addr     = a;
    sram_wdata    = we ? d : 16'h0;
    sram_rd_valid = rv;
    sram_rdata    = rv ? r.data : 16'h0;
    if (!m_block) begin
      if (rv && m_caprd) m_capture(1'b0, r.addr, r.data, req && we && m_capwr);
      else if (req && we && m_capwr) m_capture(1'b1, a, d, 1'b0);
    end
    m_block = 1'b0;
    @(posedge clk_ir);
    #1;
    cyc++;
    sram_req      = 1'b0;
    sram_we       = 1'b0;
    sram_rd_valid = 1'b0;
  endtask

  task automatic drain();
    while (pq.size() > 0) sram_step(1'b0, 1'b0, 18'd0, 16'd0);
  endtask

  task automatic lb_write(input logic [7:0] a, input logic [31:0] d);
    drain();
    lb_wr_en   = 1'b1;
    lb_addr    = a;
    lb_wr_data = d;
    m_lb_write(a, d);
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    lb_wr_en = 1'b0;
    chk("wr_ack", {31'd0, lb_wr_valid}, 32'd1);
  endtask

  task automatic arm_with_wr(input logic [17:0] a, input logic [15:0] d);
    drain();
    lb_wr_en   = 1'b1;
    lb_addr    = 8'h00;
    lb_wr_data = 32'h19;
    m_lb_write(8'h00, 32'h19);
    m_block = 1'b1;
    sram_step(1'b1, 1'b1, a, d);
    lb_wr_en = 1'b0;
    chk("arm_ev_ack", {31'd0, lb_wr_valid}, 32'd1);
  endtask

  task automatic lb_read(input string tag, input logic [7:0] a);
    logic [31:0] exp;
    drain();
    exp      = m_reg(a);
    lb_rd_en = 1'b1;
    lb_addr  = a;
    if (a == 8'h01) m_ovf = 1'b0;
    if (a == 8'h05) m_rdptr = (m_rdptr + 1) % DEPTH;
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    lb_rd_en = 1'b0;
    chk({tag, "_early"}, {31'd0, lb_rd_valid}, 32'd0);
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    chk({tag, "_vld"}, {31'd0, lb_rd_valid}, 32'd1);
    chk(tag, lb_rd_data, exp);
  endtask

  initial begin
    rst_ir = 1'b1;
    sram_req = 1'b0; sram_we = 1'b0; sram_addr = '0; sram_wdata = '0;
    sram_rd_valid = 1'b0; sram_rdata = '0;
    lb_rd_en = 1'b0; lb_wr_en = 1'b0; lb_addr = '0; lb_wr_data = '0;
    m_state = 0; m_count = 0; m_rdptr = 0; cyc = 0;
    m_ovf = 1'b0; m_capwr = 1'b1; m_caprd = 1'b1; m_block = 1'b0;
    m_ta = '0; m_tm = '0;

    repeat (3) @(posedge clk_ir);
    #1;
    chk("rst_rd_valid", {31'd0, lb_rd_valid}, 32'd0);
    chk("rst_wr_valid", {31'd0, lb_wr_valid}, 32'd0);
    chk("rst_rd_data", lb_rd_data, 32'd0);
    rst_ir = 1'b0;

    lb_read("status_rst", 8'h01);
    chk("status_rst_lit", lb_rd_data, 32'h0000_0000);
    lb_read("ctrl_rst", 8'h00);
    chk("ctrl_rst_lit", lb_rd_data, 32'h0000_0018);
    lb_read("rdptr_rst", 8'h04);
    lb_write(8'h40, 32'hFFFF_FFFF);
    lb_read("unmapped", 8'h40);
    lb_write(8'h02, 32'h0003_FFFF);
    lb_read("trig_addr", 8'h02);
    lb_write(8'h02, 32'h0);

    // Back-to-back read strobes: the second one must be ignored.
    lb_rd_en = 1'b1;
    lb_addr  = 8'h04;
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    lb_rd_en = 1'b0;
    chk("dup_vld", {31'd0, lb_rd_valid}, 32'd1);
    chk("dup_data", lb_rd_data, 32'(m_rdptr));
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    chk("dup_ignored", {31'd0, lb_rd_valid}, 32'd0);

    lb_write(8'h03, 32'h0);
    lb_write(8'h00, 32'h19);
    repeat (3) sram_step(1'b1, 1'b1, 18'h00010, 16'hA5A5);
    lb_read("status_3wr", 8'h01);
    chk("status_3wr_lit", lb_rd_data, 32'h0003_0002);
    lb_write(8'h04, 32'h0);
    lb_read("data0", 8'h05);
    chk("data0_lit", lb_rd_data, 32'h8010_A5A5);
    lb_read("rdptr_inc", 8'h04);

`ifdef SYN_VCORTEX_SRAM_DBG_TRIG_EN
    lb_write(8'h02, 32'h0000_0100);
    lb_write(8'h03, 32'h0003_FFFF);
    lb_write(8'h00, 32'h19);
    sram_step(1'b1, 1'b1, 18'h000FF, 16'h1111);
    sram_step(1'b1, 1'b1, 18'h00100, 16'h2222);
    lb_read("trig_status", 8'h01);
    lb_write(8'h04, 32'h0);
    lb_read("trig_entry0", 8'h05);
    lb_write(8'h03, 32'h0);
`endif

    lb_write(8'h00, 32'h19);
    sram_step(1'b1, 1'b0, 18'h00020, 16'h1234);
    sram_step(1'b0, 1'b0, 18'd0, 16'd0);
    sram_step(1'b1, 1'b1, 18'h00033, 16'h5555);
    lb_read("ovf_set", 8'h01);
    lb_read("ovf_clr", 8'h01);
    lb_write(8'h04, 32'h0);
    lb_read("coll_entry", 8'h05);
    chk("coll_entry_lit", lb_rd_data, 32'h0020_1234);

    lb_write(8'h00, 32'h19);
    for (int i = 0; i < DEPTH + 5; i++) sram_step(1'b1, 1'b1, 18'($urandom), 16'($urandom));
    lb_read("full_status", 8'h01);
    chk("full_status_lit", lb_rd_data, 32'h0100_0003);
    lb_write(8'h04, 32'd255);
    lb_read("full_e255", 8'h05);
    lb_read("full_e0", 8'h05);

    lb_write(8'h00, 32'h19);
    for (int i = 0; i < 10; i++) sram_step(1'b1, 1'b1, 18'($urandom), 16'($urandom));
    lb_write(8'h00, 32'h1A);
    for (int i = 0; i < 3; i++) sram_step(1'b1, 1'b1, 18'($urandom), 16'($urandom));
    lb_read("abort_status", 8'h01);
    chk("abort_status_lit", lb_rd_data, 32'h000A_0000);
    lb_write(8'h00, 32'h19);
    lb_read("rearm_status", 8'h01);

    for (int i = 0; i < 2; i++) sram_step(1'b1, 1'b1, 18'($urandom), 16'($urandom));
    arm_with_wr(18'h00777, 16'hBEEF);
    lb_read("arm_ev_status", 8'h01);

    for (int rnd = 0; rnd < 6; rnd++) begin
      int n;
      if (TRIG) begin
        lb_write(8'h02, $urandom);
        lb_write(8'h03, 32'($urandom_range(0, 3)));
      end
      lb_write(8'h00, {27'd0, 1'($urandom), 1'($urandom), 3'b001});
      for (int i = 0; i < 60; i++) begin
        int k;
        k = $urandom_range(0, 3);
        sram_step(k != 0, k != 2, 18'($urandom), 16'($urandom));
      end
      lb_read("rnd_status", 8'h01);
      lb_write(8'h04, 32'h0);
      n = (m_count < 12) ? m_count : 12;
      for (int j = 0; j < n; j++) lb_read("rnd_data", 8'h05);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
